imu_fp16_converter: RTL and testbench

IMU_FP16_CONVERTER -- requirements
Module: imu_fp16_converter

---
 rtl/imu_fp16_converter.sv | 168 ++++++++++++++++
 tb/tb_imu_fp16_converter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imu_fp16_converter.sv
// imu_fp16_converter
//   Converts a stream of six signed 16-bit IMU words (ax, ay, az, gx, gy, gz)
//   into IEEE half-precision values and presents them as one frame.
//   Each word is normalised one bit per cycle. The first word after a frame
//   hand-off, or any word flagged with raw_first, lands in the ax slot.
//
// Parameters
//   ACCEL_EXP_ADJ : power-of-two scale for words 0-2 (-14 maps 16384 to 1.0)
//   GYRO_EXP_ADJ  : power-of-two scale for words 3-5
//
// Ports
//   clk, resetn      : rising-edge clock, synchronous active-low reset
//   raw_data         : signed two's-complement sensor word
//   raw_valid        : raw_data valid
//   raw_first        : raw_data is accel_x (frame start)
//   raw_ready        : a word is accepted this cycle
//   out_ax..out_gz   : half-precision results
//   out_valid        : a complete frame is held
//   out_ready        : consumer takes the held frame
//   out_sat          : a word of the current frame was clamped
//   resync_pulse     : one-cycle pulse when the slot index is forced back to ax
module imu_fp16_converter #(
  parameter int ACCEL_EXP_ADJ = -14,
  parameter int GYRO_EXP_ADJ  = -13
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] raw_data,
  input  logic        raw_valid,
  input  logic        raw_first,
  output logic        raw_ready,
  output logic [15:0] out_ax,
  output logic [15:0] out_ay,
  output logic [15:0] out_az,
  output logic [15:0] out_gx,
  output logic [15:0] out_gy,
  output logic [15:0] out_gz,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sat,
  output logic        resync_pulse
);

  typedef enum logic [1:0] {ACCEPT, NORM, PACK, HOLD} state_t;

  localparam logic signed [9:0] ACCEL_ADJ = 10'(ACCEL_EXP_ADJ);
  localparam logic signed [9:0] GYRO_ADJ  = 10'(GYRO_EXP_ADJ);

  state_t      r_state;
  logic        r_sign;
  logic [15:0] r_mag;
  logic [3:0]  r_shiftCnt;
  logic [2:0]  r_idx;
  logic [15:0] r_slot [0:5];
  logic        r_outValid;
  logic        r_outSat;
  logic        r_resync;

  logic [15:0]       w_absData;
  logic signed [9:0] w_adj;
  logic signed [9:0] w_exp;
  logic [15:0]       w_packed;
  logic              w_packSat;

  // Magnitude as unsigned 16 bits so -32768 becomes 0x8000 without overflow.
  assign w_absData = raw_data[15] ? (~raw_data + 16'd1) : raw_data;

  assign w_adj = (r_idx < 3'd3) ? ACCEL_ADJ : GYRO_ADJ;

  // MSB position is 15 - shiftCnt, so the biased exponent p + 15 + adj
  // reduces to 30 - shiftCnt + adj.
  assign w_exp = 10'sd30 - $signed({6'd0, r_shiftCnt}) + w_adj;

  // Half-precision encoding of the normalised magnitude, clamping to the
  // largest finite value on overflow and to signed zero on underflow.
  always_comb begin
    w_packed  = 16'h0000;
    w_packSat = 1'b0;
    if (r_mag == 16'h0000) begin
      w_packed = 16'h0000;
    end else if (w_exp >= 10'sd31) begin
      w_packed  = {r_sign, 15'h7BFF};
      w_packSat = 1'b1;
    end else if (w_exp <= 10'sd0) begin
      w_packed  = {r_sign, 15'h0000};
      w_packSat = 1'b1;
    end else begin
      w_packed = {r_sign, w_exp[4:0], r_mag[14:5]};
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ACCEPT;
      r_sign     <= 1'b0;
      r_mag      <= 16'h0000;
      r_shiftCnt <= 4'd0;
      r_idx      <= 3'd0;
      r_outValid <= 1'b0;
      r_outSat   <= 1'b0;
      r_resync   <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        r_slot[i] <= 16'h0000;
      end
    end else begin
      r_resync <= 1'b0;
      case (r_state)
        ACCEPT: begin
          if (raw_valid) begin
            // A frame-start word arriving mid-frame restarts the frame at ax.
            if (raw_first && (r_idx != 3'd0)) begin
              r_idx    <= 3'd0;
              r_resync <= 1'b1;
              r_outSat <= 1'b0;
            end
            r_sign     <= raw_data[15];
            r_mag      <= w_absData;
            r_shiftCnt <= 4'd0;
            r_state    <= (w_absData != 16'h0000) ? NORM : PACK;
          end
        end
        NORM: begin
          if (r_mag[15]) begin
            r_state <= PACK;
          end else begin
            r_mag      <= {r_mag[14:0], 1'b0};
            r_shiftCnt <= r_shiftCnt + 4'd1;
          end
        end
        PACK: begin
          r_slot[r_idx] <= w_packed;
          if (w_packSat) begin
            r_outSat <= 1'b1;
          end
          if (r_idx == 3'd5) begin
            r_outValid <= 1'b1;
            r_state    <= HOLD;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_state <= ACCEPT;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_outSat   <= 1'b0;
            r_idx      <= 3'd0;
            r_state    <= ACCEPT;
          end
        end
        default: r_state <= ACCEPT;
      endcase
    end
  end

  assign raw_ready    = (r_state == ACCEPT);
  assign out_ax       = r_slot[0];
  assign out_ay       = r_slot[1];
  assign out_az       = r_slot[2];
  assign out_gx       = r_slot[3];
  assign out_gy       = r_slot[4];
  assign out_gz       = r_slot[5];
  assign out_valid    = r_outValid;
  assign out_sat      = r_outSat;
  assign resync_pulse = r_resync;

endmodule

// File: tb/tb_imu_fp16_converter.sv
// tb_imu_fp16_converter
//   Drives two converter instances in lockstep from the same inputs: one with
//   default exponent adjustments, one scaled so that accel words overflow and
//   small gyro words underflow. Expected frames are computed by a reference
//   conversion function and queued per instance when a frame is sent; they are
//   popped and compared when out_valid rises.
module tb_imu_fp16_converter;

  localparam int ACC1 = -14;
  localparam int GYR1 = -13;
  localparam int ACC2 = 2;
  localparam int GYR2 = -16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] raw_data = 16'h0000;
  logic        raw_valid = 1'b0;
  logic        raw_first = 1'b0;
  logic        out_ready = 1'b0;

  logic        raw_ready, out_valid, out_sat, resync_pulse;
  logic [15:0] out_ax, out_ay, out_az, out_gx, out_gy, out_gz;
  logic        raw_ready2, out_valid2, out_sat2, resync_pulse2;
  logic [15:0] out_ax2, out_ay2, out_az2, out_gx2, out_gy2, out_gz2;

  typedef struct packed {
    logic             sat;
    logic [5:0][15:0] w;
  } frame_t;

  frame_t sb1[$];
  frame_t sb2[$];
  frame_t lastFrame1;
  int checkCount = 0;
  int passCount = 0;
  int expIdx = 0;

  always #5 clk = ~clk;

  imu_fp16_converter #(.ACCEL_EXP_ADJ(ACC1), .GYRO_EXP_ADJ(GYR1)) dut (
    .clk(clk), .resetn(resetn), .raw_data(raw_data), .raw_valid(raw_valid),
    .raw_first(raw_first), .raw_ready(raw_ready),
    .out_ax(out_ax), .out_ay(out_ay), .out_az(out_az),
    .out_gx(out_gx), .out_gy(out_gy), .out_gz(out_gz),
    .out_valid(out_valid), .out_ready(out_ready), .out_sat(out_sat),
    .resync_pulse(resync_pulse)
  );

  imu_fp16_converter #(.ACCEL_EXP_ADJ(ACC2), .GYRO_EXP_ADJ(GYR2)) dut2 (
    .clk(clk), .resetn(resetn), .raw_data(raw_data), .raw_valid(raw_valid),
    .raw_first(raw_first), .raw_ready(raw_ready2),
    .out_ax(out_ax2), .out_ay(out_ay2), .out_az(out_az2),
    .out_gx(out_gx2), .out_gy(out_gy2), .out_gz(out_gz2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_sat(out_sat2),
    .resync_pulse(resync_pulse2)
  );

  // Reference conversion: returns {saturated, fp16}.
  function automatic logic [16:0] refConv(input logic [15:0] raw, input int adj);
    logic        s;
    logic [15:0] mag;
    logic [15:0] frac;
    int          msb;
    int          e;
    s   = raw[15];
    mag = s ? (~raw + 16'd1) : raw;
    if (mag == 16'h0000) return 17'h00000;
    msb = 0;
    for (int b = 0; b < 16; b++) begin
      if (mag[b]) msb = b;
    end
    e = msb + 15 + adj;
    if (e >= 31) return {1'b1, s, 15'h7BFF};
    if (e <= 0) return {1'b1, s, 15'h0000};
    frac = mag << (15 - msb);
    return {1'b0, s, 5'(e), frac[14:5]};
  endfunction

  function automatic frame_t buildFrame(input logic [5:0][15:0] words, input int acc, input int gyr);
    frame_t      f;
    logic [16:0] r;
    f.sat = 1'b0;
    for (int i = 0; i < 6; i++) begin
      r = refConv(words[i], (i < 3) ? acc : gyr);
      f.w[i] = r[15:0];
      f.sat  = f.sat | r[16];
    end
    return f;
  endfunction

  task automatic applyStimulus(input logic [5:0][15:0] words);
    sb1.push_back(buildFrame(words, ACC1, GYR1));
    sb2.push_back(buildFrame(words, ACC2, GYR2));
  endtask

  // Offers one word and returns #1 after the edge that accepted it.
  task automatic sendWord(input logic [15:0] d, input logic f);
    int   guard;
    logic expResync;
    raw_data  = d;
    raw_valid = 1'b1;
    raw_first = f;
    guard = 0;
    while (raw_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (raw_ready !== 1'b1) begin
      checkCount++;
      $display("[TB] FAIL send_timeout raw_ready=%b required 1", raw_ready);
      raw_valid = 1'b0;
      raw_first = 1'b0;
      return;
    end
    expResync = f && (expIdx != 0);
    @(posedge clk); #1;
    raw_valid = 1'b0;
    raw_first = 1'b0;
    checkCount++;
    if (resync_pulse !== expResync)
      $display("[TB] FAIL resync_pulse word=%h got=%b required=%b", d, resync_pulse, expResync);
    else passCount++;
    expIdx = expResync ? 1 : expIdx + 1;
  endtask

  task automatic measureLow(output int n);
    n = 0;
    while (raw_ready !== 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic checkOutput();
    int               guard;
    frame_t           e1, e2;
    logic [5:0][15:0] g1, g2;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkCount++;
    if (out_valid !== 1'b1) begin
      $display("[TB] FAIL frame_valid got=%b required=1", out_valid);
      return;
    end
    passCount++;
    checkCount++;
    if (out_valid2 !== 1'b1) $display("[TB] FAIL frame_valid2 got=%b required=1", out_valid2);
    else passCount++;
    checkCount++;
    if (sb1.size() == 0 || sb2.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty got=%0d required>0", sb1.size());
      return;
    end
    passCount++;
    e1 = sb1.pop_front();
    e2 = sb2.pop_front();
    lastFrame1 = e1;
    g1 = {out_gz, out_gy, out_gx, out_az, out_ay, out_ax};
    g2 = {out_gz2, out_gy2, out_gx2, out_az2, out_ay2, out_ax2};
    for (int i = 0; i < 6; i++) begin
      checkCount++;
      if (g1[i] !== e1.w[i]) $display("[TB] FAIL slot%0d got=%h required=%h", i, g1[i], e1.w[i]);
      else passCount++;
      checkCount++;
      if (g2[i] !== e2.w[i]) $display("[TB] FAIL slot%0d_adj got=%h required=%h", i, g2[i], e2.w[i]);
      else passCount++;
    end
    checkCount++;
    if (out_sat !== e1.sat) $display("[TB] FAIL out_sat got=%b required=%b", out_sat, e1.sat);
    else passCount++;
    checkCount++;
    if (out_sat2 !== e2.sat) $display("[TB] FAIL out_sat_adj got=%b required=%b", out_sat2, e2.sat);
    else passCount++;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    expIdx = 0;
    checkCount++;
    if ({out_valid, out_sat, out_valid2, out_sat2} !== 4'b0000)
      $display("[TB] FAIL handshake_clear got=%b required=0000", {out_valid, out_sat, out_valid2, out_sat2});
    else passCount++;
    checkCount++;
    if (raw_ready !== 1'b1) $display("[TB] FAIL handshake_ready got=%b required=1", raw_ready);
    else passCount++;
  endtask

  task automatic sendFrame(input logic [5:0][15:0] words);
    applyStimulus(words);
    for (int i = 0; i < 6; i++) sendWord(words[i], i == 0);
    checkOutput();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if ({out_gz, out_gy, out_gx, out_az, out_ay, out_ax} !== 96'h0)
      $display("[TB] FAIL reset_outputs got=%h required=0", {out_gz, out_gy, out_gx, out_az, out_ay, out_ax});
    else passCount++;
    checkCount++;
    if ({out_valid, out_sat, resync_pulse} !== 3'b000)
      $display("[TB] FAIL reset_flags got=%b required=000", {out_valid, out_sat, resync_pulse});
    else passCount++;
    resetn = 1'b1;
    expIdx = 0;
    @(posedge clk); #1;
    checkCount++;
    if (raw_ready !== 1'b1) $display("[TB] FAIL reset_ready got=%b required=1", raw_ready);
    else passCount++;
  endtask

  task automatic test_frame();
    logic [5:0][15:0] req;
    req = {16'h0800, 16'hC400, 16'h3C00, 16'h0000, 16'hBC00, 16'h3C00};
    sendFrame({16'h0001, 16'h8000, 16'h2000, 16'h0000, 16'hC000, 16'h4000});
    checkCount++;
    if ({out_gz, out_gy, out_gx, out_az, out_ay, out_ax} !== req || out_sat !== 1'b0)
      $display("[TB] FAIL frame_literal got=%h sat=%b required=%h sat=0",
               {out_gz, out_gy, out_gx, out_az, out_ay, out_ax}, out_sat, req);
    else passCount++;
    handshake();
  endtask

  task automatic test_latency();
    logic [5:0][15:0] words;
    int reqLow [4];
    int n;
    words = {16'hFFFF, 16'h1234, 16'h0001, 16'h0000, 16'h8000, 16'h4000};
    reqLow = '{3, 2, 1, 17};
    applyStimulus(words);
    for (int i = 0; i < 6; i++) begin
      sendWord(words[i], i == 0);
      if (i < 4) begin
        measureLow(n);
        checkCount++;
        if (n + 1 != reqLow[i] + 1 || n == 0)
          $display("[TB] FAIL latency word=%h got=%0d required=%0d", words[i], n, reqLow[i]);
        else passCount++;
      end
    end
    checkOutput();
  endtask

  task automatic test_backpressure();
    raw_data  = 16'h5555;
    raw_valid = 1'b1;
    raw_first = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checkCount++;
      if (raw_ready !== 1'b0 || out_valid !== 1'b1 ||
          {out_gz, out_gy, out_gx, out_az, out_ay, out_ax} !== lastFrame1.w)
        $display("[TB] FAIL backpressure cycle=%0d got=%h ready=%b valid=%b required=%h ready=0 valid=1",
                 c, {out_gz, out_gy, out_gx, out_az, out_ay, out_ax}, raw_ready, out_valid, lastFrame1.w);
      else passCount++;
    end
    raw_valid = 1'b0;
    raw_first = 1'b0;
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [5:0][15:0] words;
    logic [16:0]      r;
    int n;
    words = {16'h0600, 16'hFB00, 16'h0400, 16'h0300, 16'hFE00, 16'h7000};
    applyStimulus(words);
    sendWord(words[0], 1'b1);
    measureLow(n);
    r = refConv(words[0], ACC1);
    checkCount++;
    if (out_ax !== r[15:0]) $display("[TB] FAIL b2b_first got=%h required=%h", out_ax, r[15:0]);
    else passCount++;
    checkCount++;
    if (out_ay !== lastFrame1.w[1]) $display("[TB] FAIL retain_ay got=%h required=%h", out_ay, lastFrame1.w[1]);
    else passCount++;
    for (int i = 1; i < 6; i++) sendWord(words[i], 1'b0);
    checkOutput();
    handshake();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 6; i++) words[i] = 16'($urandom);
      sendFrame(words);
      handshake();
    end
  endtask

  task automatic test_resync();
    logic [5:0][15:0] words;
    logic [16:0]      r;
    int n;
    words = {16'h0010, 16'h0F00, 16'hA000, 16'h00FF, 16'hE000, 16'h4000};
    sendWord(16'h1000, 1'b1);
    measureLow(n);
    sendWord(16'h6000, 1'b0);
    measureLow(n);
    checkCount++;
    if (out_sat2 !== 1'b1) $display("[TB] FAIL presync_sat got=%b required=1", out_sat2);
    else passCount++;
    applyStimulus(words);
    sendWord(words[0], 1'b1);
    @(posedge clk); #1;
    checkCount++;
    if (resync_pulse !== 1'b0) $display("[TB] FAIL resync_width got=%b required=0", resync_pulse);
    else passCount++;
    checkCount++;
    if (out_sat2 !== 1'b0) $display("[TB] FAIL resync_sat_clear got=%b required=0", out_sat2);
    else passCount++;
    measureLow(n);
    checkCount++;
    if (out_ax !== 16'h3C00) $display("[TB] FAIL resync_ax got=%h required=3c00", out_ax);
    else passCount++;
    sendWord(words[1], 1'b0);
    measureLow(n);
    r = refConv(words[1], ACC1);
    checkCount++;
    if (out_ay !== r[15:0]) $display("[TB] FAIL resync_ay got=%h required=%h", out_ay, r[15:0]);
    else passCount++;
    for (int i = 2; i < 6; i++) sendWord(words[i], 1'b0);
    checkOutput();
    handshake();
  endtask

  task automatic test_saturation();
    sendFrame({16'h8001, 16'h0100, 16'h0001, 16'h0200, 16'h0100, 16'h7FFF});
    checkCount++;
    if (out_ax2 !== 16'h7BFF || out_sat2 !== 1'b1)
      $display("[TB] FAIL sat_ax got=%h sat=%b required=7bff sat=1", out_ax2, out_sat2);
    else passCount++;
    checkCount++;
    if (out_gx2 !== 16'h0000) $display("[TB] FAIL underflow_gx got=%h required=0000", out_gx2);
    else passCount++;
    handshake();
  endtask

  task automatic test_reset_midframe();
    sendWord(16'h4000, 1'b1);
    sendWord(16'h4000, 1'b0);
    sendWord(16'h4000, 1'b0);
    sendWord(16'h0001, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkCount++;
    if (raw_ready !== 1'b0) $display("[TB] FAIL midnorm_busy got=%b required=0", raw_ready);
    else passCount++;
    resetn = 1'b0;
    @(posedge clk); #1;
    checkCount++;
    if ({out_gz, out_gy, out_gx, out_az, out_ay, out_ax, out_valid, out_sat, resync_pulse, out_sat2} !== 100'h0)
      $display("[TB] FAIL midreset_clear got=%h required=0",
               {out_gz, out_gy, out_gx, out_az, out_ay, out_ax, out_valid, out_sat, resync_pulse, out_sat2});
    else passCount++;
    resetn = 1'b1;
    expIdx = 0;
    @(posedge clk); #1;
    checkCount++;
    if (raw_ready !== 1'b1) $display("[TB] FAIL midreset_ready got=%b required=1", raw_ready);
    else passCount++;
    sendFrame({16'h0001, 16'h8000, 16'h2000, 16'h0000, 16'hC000, 16'h4000});
    handshake();
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_frame();
    test_latency();
    test_backpressure();
    test_back_to_back();
    test_resync();
    test_saturation();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
